// File: rtl/serial_to_parallel_if.sv
// Serial-in / parallel-out bundle for serial_to_parallel.
// Optional parity_err signal is present only when S2P_PARITY_EN is defined.
interface serial_to_parallel_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);
  logic              in_en;
  logic              in;
  logic [CNT_W-1:0]  width;
  logic [DATA_W-1:0] out_bits;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              overrun;
  logic              clear_overrun;
`ifdef S2P_PARITY_EN
  logic              parity_err;

  modport master (
    output in_en, in, width, out_ready, clear_overrun,
    input  out_bits, out_valid, busy, overrun, parity_err
  );
  modport slave (
    input  in_en, in, width, out_ready, clear_overrun,
    output out_bits, out_valid, busy, overrun, parity_err
  );
`else
  modport master (
    output in_en, in, width, out_ready, clear_overrun,
    input  out_bits, out_valid, busy, overrun
  );
  modport slave (
    input  in_en, in, width, out_ready, clear_overrun,
    output out_bits, out_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel word assembler with one-word output buffer and
// sticky overrun flag. Define S2P_PARITY_EN for a trailing even-parity bit per word.
module serial_to_parallel #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_to_parallel_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W:0]    count_q, count_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [DATA_W-1:0] out_bits_q, out_bits_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              perr_q, perr_d;

  logic [CNT_W-1:0]  eff_width;
  logic [CNT_W:0]    len;
  logic [CNT_W:0]    last;
  logic [DATA_W-1:0] placed;
  logic [DATA_W-1:0] word;
  logic              word_perr;

  // Width is sampled from the port only for bit 0; later bits use the latched copy.
  assign eff_width = (state_q == IDLE) ? bus.width : width_q;
  assign len       = (eff_width == '0) ? (CNT_W+1)'(DATA_W) : {1'b0, eff_width};
  assign placed    = {{(DATA_W-1){1'b0}}, bus.in} << count_q[CNT_W-1:0];

`ifdef S2P_PARITY_EN
  // The strobe after the last data bit carries parity; data is already in shift_q.
  assign last      = len;
  assign word      = shift_q;
  assign word_perr = (^shift_q) ^ bus.in;
`else
  assign last      = len - 1'b1;
  assign word      = shift_q | placed;
  assign word_perr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    width_d     = width_q;
    out_bits_d  = out_bits_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    perr_d      = perr_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (bus.clear_overrun)            overrun_d   = 1'b0;

    if (bus.in_en) begin
      if (state_q == IDLE) width_d = bus.width;
      if (count_q == last) begin
        count_d = '0;
        shift_d = '0;
        state_d = IDLE;
        // A full buffer that is not being drained drops the new word.
        if (out_valid_q && !bus.out_ready) begin
          overrun_d = 1'b1;
        end else begin
          out_bits_d  = word;
          out_valid_d = 1'b1;
          perr_d      = word_perr;
        end
      end else begin
        count_d = count_q + 1'b1;
        shift_d = shift_q | placed;
        state_d = SHIFT;
      end
    end

    busy_d = (count_d != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      width_q     <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      width_q     <= width_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.out_bits  = out_bits_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;
`ifdef S2P_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q ^ word_perr;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomized + directed bench for serial_to_parallel against a queue-based word model.
module tb_serial_to_parallel;

`ifdef S2P_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clock;
  logic reset;

  serial_to_parallel_if #(.DATA_W(32), .CNT_W(5)) bus ();

  serial_to_parallel #(.DATA_W(32), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: received bits of the current word, plus the output buffer.
  bit          m_q[$];
  int          m_len;
  logic [31:0] m_out;
  bit          m_valid;
  bit          m_ovr;
  bit          m_perr;

  task automatic model_reset();
    m_q.delete();
    m_len   = 0;
    m_out   = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic model_step();
    bit consumed;
    bit loaded;
    bit setov;
    logic [31:0] w;
    bit p;
    consumed = m_valid && bus.out_ready;
    loaded   = 1'b0;
    setov    = 1'b0;
    if (bus.in_en) begin
      if (m_q.size() == 0) m_len = (bus.width == 0) ? 32 : int'(bus.width);
      m_q.push_back(bus.in);
      if (m_q.size() == m_len + PAR) begin
        w = '0;
        p = 1'b0;
        for (int k = 0; k < m_len; k++) w[k] = m_q[k];
        for (int k = 0; k < m_q.size(); k++) p = p ^ m_q[k];
        m_q.delete();
        if (m_valid && !bus.out_ready) setov = 1'b1;
        else begin
          m_out  = w;
          m_perr = p;
          loaded = 1'b1;
        end
      end
    end
    if (consumed && !loaded) m_valid = 1'b0;
    if (loaded)              m_valid = 1'b1;
    if (bus.clear_overrun)   m_ovr   = 1'b0;
    if (setov)               m_ovr   = 1'b1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check();
    cmp("out_bits",  bus.out_bits,  m_out);
    cmp("out_valid", 32'(bus.out_valid), 32'(m_valid));
    cmp("busy",      32'(bus.busy),      32'(m_q.size() != 0));
    cmp("overrun",   32'(bus.overrun),   32'(m_ovr));
`ifdef S2P_PARITY_EN
    if (m_valid) cmp("parity_err", 32'(bus.parity_err), 32'(m_perr));
`endif
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check();
  endtask

  task automatic strobe(input bit b);
    bus.in_en = 1'b1;
    bus.in    = b;
    cycle();
  endtask

  task automatic send_word(input logic [31:0] val, input int len, input bit rdy_last);
    logic [31:0] v;
    v = val;
    for (int k = 0; k < len + PAR; k++) begin
      if (k == len + PAR - 1 && rdy_last) bus.out_ready = 1'b1;
      if (k < len) strobe(v[k]);
      else         strobe(^v);
    end
    bus.in_en = 1'b0;
  endtask

  task automatic apply_reset();
    bus.in_en = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    cmp("rst_out_bits",  bus.out_bits, 32'h0);
    cmp("rst_out_valid", 32'(bus.out_valid), 32'h0);
    cmp("rst_busy",      32'(bus.busy), 32'h0);
    cmp("rst_overrun",   32'(bus.overrun), 32'h0);
    @(negedge clock);
    check();
    reset = 1'b1;
  endtask

  initial begin
    bus.in_en         = 1'b0;
    bus.in            = 1'b0;
    bus.width         = '0;
    bus.out_ready     = 1'b0;
    bus.clear_overrun = 1'b0;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    apply_reset();

    // 0xA5, width 8, continuous strobes, consumer always ready
    bus.width = 5'd8;
    bus.out_ready = 1'b1;
    send_word(32'hA5, 8, 1'b0);
    cmp("a5_valid", 32'(bus.out_valid), 32'h1);
    cmp("a5_bits",  bus.out_bits, 32'h0000_00A5);
    cmp("a5_ovr",   32'(bus.overrun), 32'h0);
    cycle();
    cmp("a5_valid_drop", 32'(bus.out_valid), 32'h0);

    // full 32-bit word via width==0
    bus.width = 5'd0;
    send_word(32'hDEAD_BEEF, 32, 1'b0);
    cmp("w32_bits", bus.out_bits, 32'hDEAD_BEEF);
    cycle();

    // toggling strobes, width changed mid-word is ignored
    bus.out_ready = 1'b0;
    bus.width = 5'd4;
    for (int k = 0; k < 4 + PAR; k++) begin
      strobe((k < 4) ? ((4'h9 >> k) & 1'b1) : 1'b0);
      if (k == 1) bus.width = 5'd2;
      bus.in_en = 1'b0;
      if (k < 3 + PAR) cycle();
    end
    cmp("nib_valid", 32'(bus.out_valid), 32'h1);
    cmp("nib_bits",  bus.out_bits, 32'h9);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;

    // overrun: second word dropped, first retained
    bus.width = 5'd4;
    send_word(32'h3, 4, 1'b0);
    send_word(32'hC, 4, 1'b0);
    cmp("ovr_bits",  bus.out_bits, 32'h3);
    cmp("ovr_flag",  32'(bus.overrun), 32'h1);
    cmp("ovr_valid", 32'(bus.out_valid), 32'h1);
    bus.clear_overrun = 1'b1;
    cycle();
    bus.clear_overrun = 1'b0;
    cmp("ovr_clear", 32'(bus.overrun), 32'h0);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;

    // consume and complete on the same edge
    bus.width = 5'd2;
    send_word(32'h1, 2, 1'b0);
    send_word(32'h2, 2, 1'b1);
    cmp("b2b_valid", 32'(bus.out_valid), 32'h1);
    cmp("b2b_bits",  bus.out_bits, 32'h2);
    cmp("b2b_ovr",   32'(bus.overrun), 32'h0);
    cycle();

    // reset in the middle of a word
    bus.width = 5'd8;
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b1);
    apply_reset();
    send_word(32'h5A, 8, 1'b0);
    cmp("post_rst_bits", bus.out_bits, 32'h5A);
    cycle();

`ifdef S2P_PARITY_EN
    // 0x07 has odd weight; parity bit 0 makes the word bad
    bus.width = 5'd8;
    for (int k = 0; k < 8; k++) strobe((8'h07 >> k) & 1'b1);
    strobe(1'b0);
    bus.in_en = 1'b0;
    cmp("par_bits", bus.out_bits, 32'h07);
    cmp("par_err",  32'(bus.parity_err), 32'h1);
    cycle();
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)
        bus.width = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 200) == 0) bus.width = 5'd1;
      bus.in_en         = ($urandom_range(0, 3) != 0);
      bus.in            = 1'($urandom);
      bus.out_ready     = ($urandom_range(0, 2) == 0);
      bus.clear_overrun = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
